change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser.sv | 261 ++++++++++++++++++++++++++
 tb/tb_change_dispenser.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Change dispenser controller.
// Pays an amount owed (in nickels) with the fewest coins the tubes can supply.
// It picks the largest coin that fits the remaining amount and still has stock.
// Each coin is requested with a one-cycle eject pulse and must be confirmed by a
// hopper acknowledge before the next coin is chosen. If no acknowledge arrives in
// time, or no coin can pay the remainder, the controller parks in FAULT.
module change_dispenser #(
    parameter int ACK_TIMEOUT = 1000,
    parameter int INIT_COUNT  = 20
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       start,
    input  logic [7:0] changeNickels,
    input  logic       hopperAck,
    input  logic       refill,
    input  logic       clearFault,
    output logic [3:0] eject,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [7:0] remaining,
    output logic [3:0] empty
);

    // The timer only has to reach ACK_TIMEOUT-1, so this width is enough.
    localparam int TIMER_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ACK_TIMEOUT - 1);
    localparam logic [7:0]         INIT_CNT   = 8'(INIT_COUNT);

    // Coin indices follow the bit order of eject and empty.
    localparam logic [1:0] COIN_NICKEL  = 2'd0;
    localparam logic [1:0] COIN_DIME    = 2'd1;
    localparam logic [1:0] COIN_QUARTER = 2'd2;
    localparam logic [1:0] COIN_DOLLAR  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SELECT   = 3'd1,
        ST_EJECT    = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_DONE     = 3'd4,
        ST_FAULT    = 3'd5
    } state_t;

    // Value of a coin expressed in nickels.
    function automatic logic [7:0] coinValue(input logic [1:0] coin);
        logic [7:0] value;
        case (coin)
            COIN_DOLLAR:  value = 8'd20;
            COIN_QUARTER: value = 8'd5;
            COIN_DIME:    value = 8'd2;
            COIN_NICKEL:  value = 8'd1;
            default:      value = 8'd0;
        endcase
        return value;
    endfunction

    // One-hot eject request for a coin.
    function automatic logic [3:0] coinOneHot(input logic [1:0] coin);
        logic [3:0] mask;
        case (coin)
            COIN_DOLLAR:  mask = 4'b1000;
            COIN_QUARTER: mask = 4'b0100;
            COIN_DIME:    mask = 4'b0010;
            COIN_NICKEL:  mask = 4'b0001;
            default:      mask = 4'b0000;
        endcase
        return mask;
    endfunction

    state_t               state_r;
    state_t               nextState_s;
    logic [7:0]           remaining_r;
    logic [7:0]           remainingNext_s;
    logic [TIMER_W-1:0]   timer_r;
    logic [TIMER_W-1:0]   timerNext_s;
    logic [3:0][7:0]      tubeCount_r;
    logic [3:0][7:0]      tubeCountNext_s;
    logic [1:0]           selCoin_r;
    logic [1:0]           selCoinNext_s;
    logic [1:0]           pickCoin_s;
    logic                 pickValid_s;
    logic [3:0]           eject_r;
    logic [3:0]           ejectNext_s;
    logic                 busy_r;
    logic                 busyNext_s;
    logic                 done_r;
    logic                 doneNext_s;
    logic                 fault_r;
    logic                 faultNext_s;

    // Greedy choice: largest coin that fits the remainder and is still stocked.
    always_comb begin
        pickValid_s = 1'b0;
        pickCoin_s  = COIN_NICKEL;
        if ((remaining_r >= 8'd20) && (tubeCount_r[COIN_DOLLAR] != 8'd0)) begin
            pickValid_s = 1'b1;
            pickCoin_s  = COIN_DOLLAR;
        end else if ((remaining_r >= 8'd5) && (tubeCount_r[COIN_QUARTER] != 8'd0)) begin
            pickValid_s = 1'b1;
            pickCoin_s  = COIN_QUARTER;
        end else if ((remaining_r >= 8'd2) && (tubeCount_r[COIN_DIME] != 8'd0)) begin
            pickValid_s = 1'b1;
            pickCoin_s  = COIN_DIME;
        end else if ((remaining_r >= 8'd1) && (tubeCount_r[COIN_NICKEL] != 8'd0)) begin
            pickValid_s = 1'b1;
            pickCoin_s  = COIN_NICKEL;
        end else begin
            pickValid_s = 1'b0;
            pickCoin_s  = COIN_NICKEL;
        end
    end

    // Next-state, datapath updates and next values of the registered outputs.
    always_comb begin
        nextState_s     = state_r;
        remainingNext_s = remaining_r;
        timerNext_s     = timer_r;
        tubeCountNext_s = tubeCount_r;
        selCoinNext_s   = selCoin_r;

        case (state_r)
            ST_IDLE: begin
                if (refill) begin
                    tubeCountNext_s = {4{INIT_CNT}};
                end else begin
                    tubeCountNext_s = tubeCount_r;
                end
                if (start) begin
                    remainingNext_s = changeNickels;
                    nextState_s     = ST_SELECT;
                end else begin
                    nextState_s = ST_IDLE;
                end
            end

            ST_SELECT: begin
                if (remaining_r == 8'd0) begin
                    nextState_s = ST_DONE;
                end else if (pickValid_s) begin
                    selCoinNext_s = pickCoin_s;
                    nextState_s   = ST_EJECT;
                end else begin
                    nextState_s = ST_FAULT;
                end
            end

            ST_EJECT: begin
                timerNext_s = {TIMER_W{1'b0}};
                nextState_s = ST_WAIT_ACK;
            end

            ST_WAIT_ACK: begin
                // An acknowledge in the last timeout cycle still counts as paid.
                if (hopperAck) begin
                    if (remaining_r >= coinValue(selCoin_r)) begin
                        remainingNext_s = remaining_r - coinValue(selCoin_r);
                    end else begin
                        remainingNext_s = 8'd0;
                    end
                    if (tubeCount_r[selCoin_r] != 8'd0) begin
                        tubeCountNext_s[selCoin_r] = tubeCount_r[selCoin_r] - 8'd1;
                    end else begin
                        tubeCountNext_s[selCoin_r] = 8'd0;
                    end
                    nextState_s = ST_SELECT;
                end else if (timer_r == TIMER_LAST) begin
                    nextState_s = ST_FAULT;
                end else begin
                    timerNext_s = timer_r + {{(TIMER_W-1){1'b0}}, 1'b1};
                    nextState_s = ST_WAIT_ACK;
                end
            end

            ST_DONE: begin
                nextState_s = ST_IDLE;
            end

            ST_FAULT: begin
                if (refill) begin
                    tubeCountNext_s = {4{INIT_CNT}};
                end else begin
                    tubeCountNext_s = tubeCount_r;
                end
                if (clearFault) begin
                    remainingNext_s = 8'd0;
                    nextState_s     = ST_IDLE;
                end else begin
                    nextState_s = ST_FAULT;
                end
            end

            default: begin
                nextState_s = ST_IDLE;
            end
        endcase

        // Outputs are registered and track the state being entered.
        if (nextState_s == ST_EJECT) begin
            ejectNext_s = coinOneHot(selCoinNext_s);
        end else begin
            ejectNext_s = 4'b0000;
        end
        busyNext_s  = (nextState_s != ST_IDLE);
        doneNext_s  = (nextState_s == ST_DONE);
        faultNext_s = (nextState_s == ST_FAULT);
    end

    // State register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Datapath registers: amount owed, ack timer, tube stock and selected coin.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            remaining_r <= 8'd0;
            timer_r     <= {TIMER_W{1'b0}};
            tubeCount_r <= {4{INIT_CNT}};
            selCoin_r   <= COIN_NICKEL;
        end else begin
            remaining_r <= remainingNext_s;
            timer_r     <= timerNext_s;
            tubeCount_r <= tubeCountNext_s;
            selCoin_r   <= selCoinNext_s;
        end
    end

    // Registered status and eject outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            eject_r <= 4'b0000;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            fault_r <= 1'b0;
        end else begin
            eject_r <= ejectNext_s;
            busy_r  <= busyNext_s;
            done_r  <= doneNext_s;
            fault_r <= faultNext_s;
        end
    end

    assign eject     = eject_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign fault     = fault_r;
    assign remaining = remaining_r;

    // Tube-empty flags come straight from the counters.
    assign empty = {tubeCount_r[COIN_DOLLAR]  == 8'd0,
                    tubeCount_r[COIN_QUARTER] == 8'd0,
                    tubeCount_r[COIN_DIME]    == 8'd0,
                    tubeCount_r[COIN_NICKEL]  == 8'd0};

endmodule

// File: tb/tb_change_dispenser.sv
// Directed testbench for change_dispenser.
// The DUT runs with one coin per tube and an 8-cycle acknowledge timeout so that
// tube depletion and timeouts are visible on the empty and fault outputs.
module tb_change_dispenser;

    logic       clk;
    logic       resetN;
    logic       start;
    logic [7:0] changeNickels;
    logic       hopperAck;
    logic       refill;
    logic       clearFault;
    logic [3:0] eject;
    logic       busy;
    logic       done;
    logic       fault;
    logic [7:0] remaining;
    logic [3:0] empty;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       st;
        logic [7:0] cn;
        logic       ack;
        logic       rf;
        logic       cf;
        logic [3:0] expEject;
        logic       expBusy;
        logic       expDone;
        logic       expFault;
        logic [7:0] expRem;
        logic [3:0] expEmpty;
    } vec_t;

    vec_t vecs[$];

    change_dispenser #(
        .ACK_TIMEOUT(8),
        .INIT_COUNT (1)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .start        (start),
        .changeNickels(changeNickels),
        .hopperAck    (hopperAck),
        .refill       (refill),
        .clearFault   (clearFault),
        .eject        (eject),
        .busy         (busy),
        .done         (done),
        .fault        (fault),
        .remaining    (remaining),
        .empty        (empty)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic add(input logic st, input logic [7:0] cn, input logic ack,
                       input logic rf, input logic cf, input logic [3:0] eEj,
                       input logic eB, input logic eD, input logic eF,
                       input logic [7:0] eR, input logic [3:0] eEm);
        vec_t v;
        v.st = st; v.cn = cn; v.ack = ack; v.rf = rf; v.cf = cf;
        v.expEject = eEj; v.expBusy = eB; v.expDone = eD; v.expFault = eF;
        v.expRem = eR; v.expEmpty = eEm;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOut(input string name, input logic [3:0] eEj, input logic eB,
                            input logic eD, input logic eF, input logic [7:0] eR,
                            input logic [3:0] eEm);
        checks++;
        if ({eject, busy, done, fault, remaining, empty} !== {eEj, eB, eD, eF, eR, eEm}) begin
            errors++;
            $display("FAIL %s: got eject=%b busy=%b done=%b fault=%b remaining=%0d empty=%b, expected eject=%b busy=%b done=%b fault=%b remaining=%0d empty=%b",
                     name, eject, busy, done, fault, remaining, empty,
                     eEj, eB, eD, eF, eR, eEm);
        end
    endtask

    task automatic idleInputs();
        start = 1'b0; changeNickels = 8'd0; hopperAck = 1'b0;
        refill = 1'b0; clearFault = 1'b0;
    endtask

    initial begin
        idleInputs();
        resetN = 1'b0;

        // Columns: start, change, ack, refill, clearFault | eject, busy, done, fault, remaining, empty
        // Greedy 27: dollar, quarter, dime; ack on the third edge after each eject.
        add(1, 27, 0, 0, 0, 4'b0000, 1, 0, 0, 27, 4'b0000);
        add(0,  0, 0, 0, 0, 4'b1000, 1, 0, 0, 27, 4'b0000);
        add(0,  0, 0, 0, 0, 4'b0000, 1, 0, 0, 27, 4'b0000);
        add(1, 99, 0, 0, 0, 4'b0000, 1, 0, 0, 27, 4'b0000);  // start while busy
        add(0,  0, 0, 0, 0, 4'b0000, 1, 0, 0, 27, 4'b0000);
        add(0,  0, 1, 0, 0, 4'b0000, 1, 0, 0,  7, 4'b1000);
        add(0,  0, 0, 0, 0, 4'b0100, 1, 0, 0,  7, 4'b1000);
        add(0,  0, 0, 0, 0, 4'b0000, 1, 0, 0,  7, 4'b1000);
        add(0,  0, 0, 1, 0, 4'b0000, 1, 0, 0,  7, 4'b1000);  // refill while busy
        add(0,  0, 0, 0, 0, 4'b0000, 1, 0, 0,  7, 4'b1000);
        add(0,  0, 1, 0, 0, 4'b0000, 1, 0, 0,  2, 4'b1100);
        add(0,  0, 1, 0, 0, 4'b0010, 1, 0, 0,  2, 4'b1100);  // ack in SELECT
        add(0,  0, 0, 0, 0, 4'b0000, 1, 0, 0,  2, 4'b1100);
        add(1,  5, 0, 0, 0, 4'b0000, 1, 0, 0,  2, 4'b1100);
        add(0,  0, 0, 0, 0, 4'b0000, 1, 0, 0,  2, 4'b1100);
        add(0,  0, 1, 0, 0, 4'b0000, 1, 0, 0,  0, 4'b1110);
        add(0,  0, 0, 0, 0, 4'b0000, 1, 1, 0,  0, 4'b1110);
        add(0,  0, 0, 0, 0, 4'b0000, 0, 0, 0,  0, 4'b1110);
        // Tube fallback for 8: quarter, dime, nickel; then 1 cannot be paid.
        add(0,  0, 0, 1, 0, 4'b0000, 0, 0, 0,  0, 4'b0000);
        add(1,  8, 0, 0, 0, 4'b0000, 1, 0, 0,  8, 4'b0000);
        add(0,  0, 0, 0, 0, 4'b0100, 1, 0, 0,  8, 4'b0000);
        add(0,  0, 0, 0, 0, 4'b0000, 1, 0, 0,  8, 4'b0000);
        add(0,  0, 1, 0, 0, 4'b0000, 1, 0, 0,  3, 4'b0100);
        add(0,  0, 0, 0, 0, 4'b0010, 1, 0, 0,  3, 4'b0100);
        add(0,  0, 0, 0, 0, 4'b0000, 1, 0, 0,  3, 4'b0100);
        add(0,  0, 1, 0, 0, 4'b0000, 1, 0, 0,  1, 4'b0110);
        add(0,  0, 0, 0, 0, 4'b0001, 1, 0, 0,  1, 4'b0110);
        add(0,  0, 0, 0, 0, 4'b0000, 1, 0, 0,  1, 4'b0110);
        add(0,  0, 1, 0, 0, 4'b0000, 1, 0, 0,  0, 4'b0111);
        add(0,  0, 0, 0, 0, 4'b0000, 1, 1, 0,  0, 4'b0111);
        add(0,  0, 0, 0, 0, 4'b0000, 0, 0, 0,  0, 4'b0111);
        add(1,  1, 0, 0, 0, 4'b0000, 1, 0, 0,  1, 4'b0111);
        add(0,  0, 0, 0, 0, 4'b0000, 1, 0, 1,  1, 4'b0111);
        add(0,  0, 0, 0, 0, 4'b0000, 1, 0, 1,  1, 4'b0111);
        add(0,  0, 0, 1, 0, 4'b0000, 1, 0, 1,  1, 4'b0000);  // refill in FAULT
        add(1,  5, 0, 0, 0, 4'b0000, 1, 0, 1,  1, 4'b0000);  // start in FAULT
        add(0,  0, 0, 0, 1, 4'b0000, 0, 0, 0,  0, 4'b0000);
        // Timeout: eject, eight unacknowledged cycles, then FAULT.
        add(1,  1, 0, 0, 0, 4'b0000, 1, 0, 0,  1, 4'b0000);
        add(0,  0, 0, 0, 0, 4'b0001, 1, 0, 0,  1, 4'b0000);
        for (int k = 0; k < 8; k++) add(0, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 1, 4'b0000);
        add(0,  0, 0, 0, 0, 4'b0000, 1, 0, 1,  1, 4'b0000);
        add(0,  0, 0, 0, 1, 4'b0000, 0, 0, 0,  0, 4'b0000);
        // Ack arriving in the timeout cycle wins.
        add(1,  1, 0, 0, 0, 4'b0000, 1, 0, 0,  1, 4'b0000);
        add(0,  0, 0, 0, 0, 4'b0001, 1, 0, 0,  1, 4'b0000);
        for (int k = 0; k < 8; k++) add(0, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 1, 4'b0000);
        add(0,  0, 1, 0, 0, 4'b0000, 1, 0, 0,  0, 4'b0001);
        add(0,  0, 0, 0, 0, 4'b0000, 1, 1, 0,  0, 4'b0001);
        add(0,  0, 0, 0, 0, 4'b0000, 0, 0, 0,  0, 4'b0001);

        // Reset state.
        step();
        step();
        checkOut("reset_state", 4'b0000, 0, 0, 0, 8'd0, 4'b0000);
        resetN = 1'b1;
        step();
        checkOut("idle_after_reset", 4'b0000, 0, 0, 0, 8'd0, 4'b0000);

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].st; changeNickels = vecs[i].cn; hopperAck = vecs[i].ack;
            refill = vecs[i].rf; clearFault = vecs[i].cf;
            step();
            checkOut($sformatf("vec%0d", i), vecs[i].expEject, vecs[i].expBusy,
                     vecs[i].expDone, vecs[i].expFault, vecs[i].expRem, vecs[i].expEmpty);
        end
        idleInputs();

        // Zero change: done two edges after start, never an eject pulse.
        start = 1'b1; changeNickels = 8'd0;
        step();
        checkOut("zero_select", 4'b0000, 1, 0, 0, 8'd0, 4'b0001);
        idleInputs();
        step();
        checkOut("zero_done", 4'b0000, 1, 1, 0, 8'd0, 4'b0001);
        step();
        checkOut("zero_idle", 4'b0000, 0, 0, 0, 8'd0, 4'b0001);

        // Asynchronous reset while waiting for an acknowledge.
        start = 1'b1; changeNickels = 8'd20;
        step();
        idleInputs();
        checkOut("rst_select", 4'b0000, 1, 0, 0, 8'd20, 4'b0001);
        step();
        checkOut("rst_eject", 4'b1000, 1, 0, 0, 8'd20, 4'b0001);
        step();
        checkOut("rst_wait", 4'b0000, 1, 0, 0, 8'd20, 4'b0001);
        #2;
        resetN = 1'b0;
        #1;
        checkOut("rst_async", 4'b0000, 0, 0, 0, 8'd0, 4'b0000);
        step();
        step();
        checkOut("rst_held", 4'b0000, 0, 0, 0, 8'd0, 4'b0000);
        #2;
        resetN = 1'b1;
        step();
        checkOut("rst_released", 4'b0000, 0, 0, 0, 8'd0, 4'b0000);
        hopperAck = 1'b1;
        step();
        hopperAck = 1'b0;
        checkOut("rst_ack_ignored", 4'b0000, 0, 0, 0, 8'd0, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
